// File: rtl/req_encoder_if.sv
// rtl/req_encoder_if.sv - request/code handshake bundle for req_encoder
//
// Signals
//   E     enable for incoming requests (source -> encoder)
//   I     request pulses, one bit per source (source -> encoder)
//   R     consumer ready (consumer -> encoder)
//   O     encoded index of the presented request (encoder -> consumer)
//   V     O is valid (encoder -> consumer)
//   pend  pending-request register, presented entry excluded (encoder -> observer)
//   ovf   sticky lost-request flag (encoder -> observer)
// Modports
//   master  request source / code consumer side
//   slave   encoder side
interface req_encoder_if #(
    parameter int N = 4,
    parameter int W = 2
);
    logic         E;
    logic [N-1:0] I;
    logic         R;
    logic [W-1:0] O;
    logic         V;
    logic [N-1:0] pend;
    logic         ovf;

    modport master (
        output E, I, R,
        input  O, V, pend, ovf
    );

    modport slave (
        input  E, I, R,
        output O, V, pend, ovf
    );
endinterface

// File: rtl/req_encoder.sv
// rtl/req_encoder.sv - sequential N-to-log2(N) priority encoder with pending register
//
// Captures request pulses into a pending register and drains them one per
// valid/ready handshake, highest index first, as a binary code.
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   req_encoder_if.slave: E/I/R in, O/V/pend/ovf out
module req_encoder #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic           clk,
    input  logic           rst,
    req_encoder_if.slave   bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [W-1:0] code_q;
    logic [N-1:0] pend_q;
    logic         ovf_q;

    logic [W-1:0] sel_idx;
    logic         pend_any;
    logic         load;
    logic [N-1:0] clr;
    logic [N-1:0] req_in;

    // Highest set bit of the registered pending vector; the ascending loop
    // lets higher indices overwrite lower ones.
    always_comb begin
        sel_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (pend_q[k]) begin
                sel_idx = W'(k);
            end
        end
    end

    assign pend_any = |pend_q;
    assign req_in   = bus.E ? bus.I : '0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: the output slot frees up when empty or on a handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (pend_any) state_d = FULL;
            FULL:  if (bus.R && !pend_any) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Output/control logic: decide whether a pending entry moves to O.
    always_comb begin
        load = 1'b0;
        case (state_q)
            EMPTY: load = pend_any;
            FULL:  load = bus.R && pend_any;
            default: load = 1'b0;
        endcase
        clr = load ? ({{(N-1){1'b0}}, 1'b1} << sel_idx) : '0;
    end

    // Datapath: code register, pending capture, sticky overflow.
    // New requests are OR'd after the clear so a set on the same bit wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q <= '0;
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (load) begin
                code_q <= sel_idx;
            end
            pend_q <= (pend_q & ~clr) | req_in;
            if (|(req_in & pend_q & ~clr)) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.O    = code_q;
    assign bus.V    = (state_q == FULL);
    assign bus.pend = pend_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_req_encoder.sv
// tb/tb_req_encoder.sv - directed self-checking bench for req_encoder
module tb_req_encoder;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    req_encoder_if #(.N(4), .W(2)) bus ();

    req_encoder #(.N(4), .W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.E = 1'b0;
        bus.I = 4'h0;
        bus.R = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.E = 1'b1;
        bus.I = 4'hF;
        bus.R = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (bus.O !== 2'd0 || bus.V !== 1'b0 || bus.pend !== 4'h0 || bus.ovf !== 1'b0) begin
                $display("FAIL reset cyc%0d: O=%0d V=%b pend=%b ovf=%b, required O=0 V=0 pend=0000 ovf=0",
                         c, bus.O, bus.V, bus.pend, bus.ovf);
                failures++;
            end
        end
        bus.E = 1'b0;
        bus.I = 4'h0;
        bus.R = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        bus.E = 1'b1;
        bus.R = 1'b1;
        bus.I = 4'b0100;
        tick();
        bus.I = 4'h0;
        checks++;
        if (bus.V !== 1'b0 || bus.pend !== 4'b0100) begin
            $display("FAIL single_capture: V=%b pend=%b, required V=0 pend=0100", bus.V, bus.pend);
            failures++;
        end
        tick();
        checks++;
        if (bus.V !== 1'b1 || bus.O !== 2'd2 || bus.pend !== 4'h0) begin
            $display("FAIL single_present: V=%b O=%0d pend=%b, required V=1 O=2 pend=0000", bus.V, bus.O, bus.pend);
            failures++;
        end
        tick();
        checks++;
        if (bus.V !== 1'b0 || bus.O !== 2'd2) begin
            $display("FAIL single_drain: V=%b O=%0d, required V=0 O=2 (held)", bus.V, bus.O);
            failures++;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_o [3];
        logic [3:0] exp_p [3];
        exp_o[0] = 2'd3; exp_p[0] = 4'b0011;
        exp_o[1] = 2'd1; exp_p[1] = 4'b0001;
        exp_o[2] = 2'd0; exp_p[2] = 4'b0000;
        do_reset();
        bus.E = 1'b1;
        bus.R = 1'b1;
        bus.I = 4'b1011;
        tick();
        bus.I = 4'h0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus.V !== 1'b1 || bus.O !== exp_o[c] || bus.pend !== exp_p[c]) begin
                $display("FAIL b2b_code%0d: V=%b O=%0d pend=%b, required V=1 O=%0d pend=%b",
                         c, bus.V, bus.O, bus.pend, exp_o[c], exp_p[c]);
                failures++;
            end
        end
        tick();
        checks++;
        if (bus.V !== 1'b0) begin
            $display("FAIL b2b_end: V=%b, required V=0", bus.V);
            failures++;
        end
    endtask

    task automatic test_hold();
        do_reset();
        bus.E = 1'b1;
        bus.R = 1'b0;
        bus.I = 4'b0010;
        tick();
        bus.I = 4'h0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (bus.V !== 1'b1 || bus.O !== 2'd1) begin
                $display("FAIL hold_cyc%0d: V=%b O=%0d, required V=1 O=1", c, bus.V, bus.O);
                failures++;
            end
        end
        bus.R = 1'b1;
        tick();
        checks++;
        if (bus.V !== 1'b0) begin
            $display("FAIL hold_release: V=%b, required V=0", bus.V);
            failures++;
        end
    endtask

    task automatic test_disable();
        do_reset();
        bus.E = 1'b0;
        bus.R = 1'b1;
        bus.I = 4'hF;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus.V !== 1'b0 || bus.pend !== 4'h0 || bus.ovf !== 1'b0) begin
                $display("FAIL disable_cyc%0d: V=%b pend=%b ovf=%b, required V=0 pend=0000 ovf=0",
                         c, bus.V, bus.pend, bus.ovf);
                failures++;
            end
        end
        bus.I = 4'h0;
        tick();
        checks++;
        if (bus.V !== 1'b0) begin
            $display("FAIL disable_after: V=%b, required V=0", bus.V);
            failures++;
        end
    endtask

    task automatic test_set_wins();
        do_reset();
        bus.E = 1'b1;
        bus.R = 1'b0;
        bus.I = 4'b0100;
        tick();
        // Same bit re-requested on the edge it moves to O: stays pending, no overflow.
        tick();
        bus.I = 4'h0;
        checks++;
        if (bus.V !== 1'b1 || bus.O !== 2'd2 || bus.pend !== 4'b0100 || bus.ovf !== 1'b0) begin
            $display("FAIL set_wins: V=%b O=%0d pend=%b ovf=%b, required V=1 O=2 pend=0100 ovf=0",
                     bus.V, bus.O, bus.pend, bus.ovf);
            failures++;
        end
        bus.R = 1'b1;
        tick();
        checks++;
        if (bus.V !== 1'b1 || bus.O !== 2'd2 || bus.pend !== 4'h0) begin
            $display("FAIL set_wins_again: V=%b O=%0d pend=%b, required V=1 O=2 pend=0000", bus.V, bus.O, bus.pend);
            failures++;
        end
        tick();
        checks++;
        if (bus.V !== 1'b0) begin
            $display("FAIL set_wins_end: V=%b, required V=0", bus.V);
            failures++;
        end
    endtask

    task automatic test_overflow();
        do_reset();
        bus.E = 1'b1;
        bus.R = 1'b0;
        bus.I = 4'b1001;
        tick();
        bus.I = 4'h0;
        tick();
        checks++;
        if (bus.V !== 1'b1 || bus.O !== 2'd3 || bus.pend !== 4'b0001 || bus.ovf !== 1'b0) begin
            $display("FAIL ovf_present: V=%b O=%0d pend=%b ovf=%b, required V=1 O=3 pend=0001 ovf=0",
                     bus.V, bus.O, bus.pend, bus.ovf);
            failures++;
        end
        // Re-request of the presented index is not an overflow.
        bus.I = 4'b1000;
        tick();
        checks++;
        if (bus.pend !== 4'b1001 || bus.ovf !== 1'b0 || bus.O !== 2'd3) begin
            $display("FAIL ovf_represent: O=%0d pend=%b ovf=%b, required O=3 pend=1001 ovf=0",
                     bus.O, bus.pend, bus.ovf);
            failures++;
        end
        bus.I = 4'b0001;
        tick();
        bus.I = 4'h0;
        checks++;
        if (bus.ovf !== 1'b1 || bus.pend !== 4'b1001) begin
            $display("FAIL ovf_set: ovf=%b pend=%b, required ovf=1 pend=1001", bus.ovf, bus.pend);
            failures++;
        end
        tick();
        checks++;
        if (bus.ovf !== 1'b1) begin
            $display("FAIL ovf_sticky: ovf=%b, required ovf=1", bus.ovf);
            failures++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.V !== 1'b0 || bus.pend !== 4'h0 || bus.ovf !== 1'b0 || bus.O !== 2'd0) begin
            $display("FAIL ovf_reset: V=%b O=%0d pend=%b ovf=%b, required V=0 O=0 pend=0000 ovf=0",
                     bus.V, bus.O, bus.pend, bus.ovf);
            failures++;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.E = 1'b0;
        bus.I = 4'h0;
        bus.R = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_disable();
        test_set_wins();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
